// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit bus datapath.
// It sequences the fetch (T0-T2) and the register-register ALU execute (T3-T5)
// cycles, and it decodes IR into bus-source, load-enable and ALU strobes.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset to IDLE
//   run             1 = run continuously, 0 = stop after the current instruction
//   step            (SINGLE_STEP_EN only) advances one instruction out of PAUSE
//   ir              IR contents: opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
//   PCout, Zlowout, MDRout                     bus source enables
//   PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in   register load enables
//   Inc_PC, read                               PC increment, memory read
//   r_in, r_out     one-hot general register load / bus drive strobes
//   ALU_select      ALU operation code (opcode during T4, else 0)
//   busy, halted    status; illegal pulses in T3 on an undefined opcode
//
// Optional feature macro: SINGLE_STEP_EN adds the step input and a PAUSE state
// that is entered after every completed instruction.
//
// Outputs are a Moore decode of the state, so an asynchronous reset clears
// them at once. The decode reads ir directly because IR is stable after T2.

module control_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
`ifdef SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                PC_in,
  output logic                IR_in,
  output logic                Y_in,
  output logic                Z_in,
  output logic                MAR_in,
  output logic                MDR_in,
  output logic                Inc_PC,
  output logic                read,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic [4:0]          ALU_select,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned WAIT_W = 3;
  localparam logic [4:0]  OP_ALU_MAX = 5'd12;
  localparam logic [4:0]  OP_HALT    = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  logic [4:0] opcode;
  logic       op_alu;
  logic       op_halt;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign op_alu    = (opcode <= OP_ALU_MAX);
  assign op_halt   = (opcode == OP_HALT);
  assign unused_ir = ^ir[14:0];

  // Register field to strobe index, reduced modulo NUM_REGS.
  function automatic logic [IDX_W-1:0] reg_idx(input logic [3:0] field);
    return IDX_W'(32'(field) % NUM_REGS);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Counts T1 cycles so the memory read can be stretched by MEM_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               wait_cnt <= '0;
    else if (state == S_T1 && wait_cnt != WAIT_W'(MEM_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
    else                                                     wait_cnt <= '0;
  end

  // Next-state logic.
  always_comb begin
    state_t after_instr;
`ifdef SINGLE_STEP_EN
    after_instr = run ? S_PAUSE : S_IDLE;
`else
    after_instr = run ? S_T0 : S_IDLE;
`endif
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    if (wait_cnt == WAIT_W'(MEM_WAIT)) state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3: begin
        if (op_alu)       state_nxt = S_T4;
        else if (op_halt) state_nxt = S_HALT;
        else              state_nxt = after_instr;
      end
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = after_instr;
      S_HALT:  state_nxt = S_HALT;
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (!run)      state_nxt = S_IDLE;
        else if (step) state_nxt = S_T0;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    PC_in      = 1'b0;
    IR_in      = 1'b0;
    Y_in       = 1'b0;
    Z_in       = 1'b0;
    MAR_in     = 1'b0;
    MDR_in     = 1'b0;
    Inc_PC     = 1'b0;
    read       = 1'b0;
    r_in       = '0;
    r_out      = '0;
    ALU_select = 5'd0;
    illegal    = 1'b0;
    busy       = (state != S_IDLE) && (state != S_HALT);
    halted     = (state == S_HALT);
    case (state)
      S_T0: begin
        PCout  = 1'b1;
        MAR_in = 1'b1;
        Inc_PC = 1'b1;
        Z_in   = 1'b1;
      end
      S_T1: begin
        read = 1'b1;
        // The incremented PC is written back only once per stretched read.
        if (wait_cnt == '0) begin
          Zlowout = 1'b1;
          PC_in   = 1'b1;
        end
        if (wait_cnt == WAIT_W'(MEM_WAIT)) MDR_in = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IR_in  = 1'b1;
      end
      S_T3: begin
        if (op_alu) begin
          r_out[reg_idx(ir[22:19])] = 1'b1;
          Y_in = 1'b1;
        end else if (!op_halt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        r_out[reg_idx(ir[18:15])] = 1'b1;
        ALU_select = opcode;
        Z_in       = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        r_in[reg_idx(ir[26:23])] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT = 0 and 3) share
// stimulus; each is compared every cycle with a phase-based instruction model.

module tb_control_sequencer;

  localparam int unsigned NR = 16;
  localparam int unsigned OW = 19 + 2 * NR;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_PAUSE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic [31:0] ir = 32'h0;

  logic          pco [2], zlo [2], mdro [2], pci [2], iri [2], yi [2], zi [2];
  logic          mari [2], mdri [2], incpc [2], rd [2], bsy [2], hlt [2], ill [2];
  logic [NR-1:0] ri [2], ro [2];
  logic [4:0]    alu [2];
  logic [OW-1:0] obs [2];

  int mode  [2];
  int phase [2];
  int wdut  [2];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(0), .NUM_REGS(NR)) u_w0 (
    .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir),
    .PCout(pco[0]), .Zlowout(zlo[0]), .MDRout(mdro[0]),
    .PC_in(pci[0]), .IR_in(iri[0]), .Y_in(yi[0]), .Z_in(zi[0]),
    .MAR_in(mari[0]), .MDR_in(mdri[0]), .Inc_PC(incpc[0]), .read(rd[0]),
    .r_in(ri[0]), .r_out(ro[0]), .ALU_select(alu[0]),
    .busy(bsy[0]), .halted(hlt[0]), .illegal(ill[0])
  );

  control_sequencer #(.MEM_WAIT(3), .NUM_REGS(NR)) u_w3 (
    .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir),
    .PCout(pco[1]), .Zlowout(zlo[1]), .MDRout(mdro[1]),
    .PC_in(pci[1]), .IR_in(iri[1]), .Y_in(yi[1]), .Z_in(zi[1]),
    .MAR_in(mari[1]), .MDR_in(mdri[1]), .Inc_PC(incpc[1]), .read(rd[1]),
    .r_in(ri[1]), .r_out(ro[1]), .ALU_select(alu[1]),
    .busy(bsy[1]), .halted(hlt[1]), .illegal(ill[1])
  );

  always_comb begin
    for (int k = 0; k < 2; k++)
      obs[k] = {pco[k], zlo[k], mdro[k], pci[k], iri[k], yi[k], zi[k], mari[k],
                mdri[k], incpc[k], rd[k], ri[k], ro[k], alu[k], bsy[k], hlt[k], ill[k]};
  end

  // Expected outputs for a given position within an instruction. Phase 0 is
  // T0, phases 1..w+1 the (stretched) read, then w+2 = T2, w+3 = T3, ...
  function automatic logic [OW-1:0] model_out(input int m, input int p, input int w,
                                              input logic [31:0] iv);
    logic a_pco, a_zlo, a_mdro, a_pci, a_iri, a_yi, a_zi, a_mari, a_mdri;
    logic a_inc, a_rd, a_bsy, a_hlt, a_ill;
    logic [NR-1:0] a_ri, a_ro;
    logic [4:0] a_alu;
    int op;
    op = int'(iv[31:27]);
    {a_pco, a_zlo, a_mdro, a_pci, a_iri, a_yi, a_zi, a_mari, a_mdri} = '0;
    {a_inc, a_rd, a_bsy, a_hlt, a_ill} = '0;
    a_ri = '0;
    a_ro = '0;
    a_alu = '0;
    if (m == M_HALT) a_hlt = 1'b1;
    if (m == M_PAUSE) a_bsy = 1'b1;
    if (m == M_RUN) begin
      a_bsy = 1'b1;
      if (p == 0) begin
        a_pco = 1'b1; a_mari = 1'b1; a_inc = 1'b1; a_zi = 1'b1;
      end else if (p <= w + 1) begin
        a_rd = 1'b1;
        if (p == 1) begin a_zlo = 1'b1; a_pci = 1'b1; end
        if (p == w + 1) a_mdri = 1'b1;
      end else if (p == w + 2) begin
        a_mdro = 1'b1; a_iri = 1'b1;
      end else if (p == w + 3) begin
        if (op <= 12) begin
          a_ro[int'(iv[22:19]) % NR] = 1'b1;
          a_yi = 1'b1;
        end else if (op != 27) begin
          a_ill = 1'b1;
        end
      end else if (p == w + 4) begin
        a_ro[int'(iv[18:15]) % NR] = 1'b1;
        a_alu = iv[31:27];
        a_zi = 1'b1;
      end else begin
        a_zlo = 1'b1;
        a_ri[int'(iv[26:23]) % NR] = 1'b1;
      end
    end
    return {a_pco, a_zlo, a_mdro, a_pci, a_iri, a_yi, a_zi, a_mari, a_mdri,
            a_inc, a_rd, a_ri, a_ro, a_alu, a_bsy, a_hlt, a_ill};
  endfunction

  // Advance one model by one clock edge using the inputs seen at that edge.
  task automatic model_step(input int k);
    int op;
    bit done;
    op = int'(ir[31:27]);
    if (reset) begin
      mode[k] = M_IDLE; phase[k] = 0;
      return;
    end
    done = 1'b0;
    case (mode[k])
      M_IDLE: if (run) begin mode[k] = M_RUN; phase[k] = 0; end
      M_RUN: begin
        if (phase[k] == wdut[k] + 3 && op == 27) mode[k] = M_HALT;
        else if (phase[k] == wdut[k] + 3 && op > 12) done = 1'b1;
        else if (phase[k] == wdut[k] + 5) done = 1'b1;
        else phase[k]++;
      end
`ifdef SINGLE_STEP_EN
      M_PAUSE: begin
        if (!run) mode[k] = M_IDLE;
        else if (step) begin mode[k] = M_RUN; phase[k] = 0; end
      end
`endif
      default: ;
    endcase
    if (done) begin
      phase[k] = 0;
`ifdef SINGLE_STEP_EN
      mode[k] = run ? M_PAUSE : M_IDLE;
`else
      mode[k] = run ? M_RUN : M_IDLE;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    logic [OW-1:0] e;
    for (int k = 0; k < 2; k++) begin
      e = model_out(mode[k], phase[k], wdut[k], ir);
      n_assert++;
      assert (obs[k] === e) else begin
        n_fail++;
        $error("FAIL %s dut_w%0d cyc=%0d observed=%h expected=%h", tag, wdut[k], cyc, obs[k], e);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input logic [31:0] new_ir);
    reset = 1'b1;
    run   = 1'b0;
    ir    = new_ir;
    mode[0] = M_IDLE; mode[1] = M_IDLE;
    #1;
    check_all("reset_async");
    tick("reset_hold");
    reset = 1'b0;
  endtask

  initial begin
    mode[0] = M_IDLE; mode[1] = M_IDLE;
    phase[0] = 0; phase[1] = 0;
    wdut[0] = 0; wdut[1] = 3;

    #2;
    check_all("reset_state");
    tick("reset_state");

    // Directed ALU instruction: opcode 9, ra 5, rb 2, rc 4.
    do_reset(32'h4A92_0000);
    tick("idle_run_low");
    run = 1'b1;
    for (int i = 0; i < 30; i++) tick("alu_op9");

    // Asynchronous reset in the middle of T4 of the MEM_WAIT = 0 instance.
    for (int i = 0; i < 20 && !(mode[0] == M_RUN && phase[0] == 4); i++) tick("seek_t4");
    n_assert++;
    assert (mode[0] == M_RUN && phase[0] == 4) else begin
      n_fail++;
      $error("FAIL seek_t4_timeout observed_phase=%0d expected_phase=4", phase[0]);
    end
    #3;
    reset = 1'b1;
    mode[0] = M_IDLE; mode[1] = M_IDLE;
    #1;
    check_all("reset_mid_t4");
    run = 1'b0;
    tick("reset_mid_t4_hold");
    reset = 1'b0;
    tick("idle_after_reset");
    tick("idle_after_reset");
    run = 1'b1;
    tick("first_t0_after_run");
    for (int i = 0; i < 12; i++) tick("alu_after_reset");

    // Undefined opcode 5'b11110.
    do_reset(32'hF000_0000);
    run = 1'b1;
    for (int i = 0; i < 20; i++) tick("illegal_op");

    // Halt opcode with run toggling once halted.
    do_reset(32'hD800_0000);
    run = 1'b1;
    for (int i = 0; i < 12; i++) tick("halt_enter");
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom_range(0, 1));
      tick("halt_stay");
    end

    // Random instructions with random run drops.
    for (int r = 0; r < 12; r++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 12))
                                       : 5'($urandom_range(13, 31));
      do_reset({op, 27'($urandom)});
      run = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick("random");
        run = ($urandom_range(0, 3) != 0);
      end
    end

`ifdef SINGLE_STEP_EN
    // Single-step: park in PAUSE, then launch exactly one instruction.
    do_reset(32'h4A92_0000);
    run = 1'b1;
    for (int i = 0; i < 16; i++) tick("pause_enter");
    step = 1'b1;
    tick("step_pulse");
    step = 1'b0;
    for (int i = 0; i < 16; i++) tick("step_one");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the existing 32-bit bus datapath through fetch (T0–T2) and register-register ALU execute (T3–T5).
- Replaces the hand-timed testbench stimulus with a clocked state machine.
- Decodes the instruction held in IR and issues one-hot register in/out strobes, bus-source selects, load enables and the ALU operation code.

Parameters:
- MEM_WAIT, 0, extra cycles T1 holds read before MDR_in is asserted (0..7).
- NUM_REGS, 16, size of general register file; width of the one-hot strobe buses.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- run  in  1  level; 1 = fetch/execute continuously, 0 = stop after the current instruction.
- ir  in  32  IR contents; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
- PCout, Zlowout, MDRout  out  1 each  bus source enables.
- PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in  out  1 each  register load enables.
- Inc_PC, read  out  1 each  PC increment select; memory read / MDR mux select.
- r_in  out  NUM_REGS  one-hot register load strobe.
- r_out  out  NUM_REGS  one-hot register bus drive.
- ALU_select  out  5  ALU operation code.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT. State register is the only sequential element besides the wait counter.
- Reset (async, any state, mid-instruction included): state = IDLE, wait counter = 0. All outputs 0 while reset is high and in IDLE.
- Outputs are a Moore decode of the state and the registered ir fields. ir is stable after T2. At most one bus source is high in any cycle.
- IDLE: all outputs 0. Go to T0 when run = 1.
- T0: PCout, MAR_in, Inc_PC, Z_in = 1. Next state T1.
- T1: Zlowout, PC_in = 1 on the first T1 cycle only. read = 1 on every T1 cycle.
  - Stay in T1 for MEM_WAIT+1 cycles total.
  - MDR_in = 1 only on the last T1 cycle. Next state T2.
- T2: MDRout, IR_in = 1. Next state T3.
- T3 decode, by opcode:
  - Opcode 0..12 (ALU): r_out[rb] = 1, Y_in = 1. Next state T4.
  - Opcode 5'b11011 (halt): no strobes. Next state HALT.
  - Any other opcode: illegal = 1 for this cycle, no strobes, PC already advanced. Next state T0 if run, else IDLE.
- T4: r_out[rc] = 1, ALU_select = opcode, Z_in = 1. Next state T5.
- T5: Zlowout = 1, r_in[ra] = 1. Next state T0 if run = 1, else IDLE.
- HALT: halted = 1, all other outputs 0. Leave only via reset.
- Index rule: register fields wider than log2(NUM_REGS) are truncated modulo NUM_REGS. ra = rb = rc is legal.
- run deasserted mid-instruction: the instruction completes through T5 (or T3 for illegal), then the sequencer goes to IDLE.
- ALU_select = 0 outside T4.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After T5 or an illegal T3, the sequencer enters state PAUSE (all outputs 0, busy = 1) instead of T0.
  - PAUSE advances to T0 on the cycle step = 1 and run = 1, and goes to IDLE if run = 0.
- Undefined: no step port, no PAUSE state; behaviour as above.

Test Plan:
- Reset mid-T4 (assert reset asynchronously between edges) -> all outputs 0 immediately; state IDLE; first T0 appears one cycle after run returns to 1.
- run = 1, MEM_WAIT = 0, ir = 0x4A920000 (opcode 9, ra = 5, rb = 2, rc = 4) -> exactly 6 cycles per instruction:
  - T3: r_out = 0x0004, Y_in = 1.
  - T4: r_out = 0x0010, ALU_select = 9.
  - T5: r_in = 0x0020, Zlowout = 1.
  - Then T0 again.
- MEM_WAIT = 3 -> read high for 4 consecutive cycles; PC_in only in the first; MDR_in only in the fourth; instruction length 9 cycles.
- ir opcode 5'b11011 -> HALT after T3; halted = 1, busy = 0; stays there with run toggling; exits only on reset.
- ir opcode 5'b11110 -> illegal pulses for 1 cycle in T3; no r_in/r_out/Z_in activity; next cycle is T0 with PCout = 1.
- With SINGLE_STEP_EN and run = 1 -> sequencer stops in PAUSE after T5; a step pulse of 1 cycle launches exactly one further instruction.
